// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serdes types and defaults
//
// Purpose: common definitions for the serdes serializer and deserializer.
// Ports: none (package).
package serdes_pkg;

  // Default serial word width.
  localparam int unsigned DATA_W_DEF = 8;

  // Default input FIFO depth (power of two, >= 2).
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  // Level driven on the serial line while no word is being shifted.
  localparam bit IDLE_LEVEL_DEF = 1'b0;

  // Shifter control states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage : serdes_pkg

// File: rtl/serdes_sync_fifo.sv
// rtl/serdes_sync_fifo.sv - synchronous FIFO feeding the serializer shifter
//
// Purpose: buffers parallel words between the producer and the shifter.
// Ports:
//   clk         in   clock, all logic on posedge
//   rst         in   synchronous active-high reset, flushes the FIFO
//   push_valid  in   producer offers push_data
//   push_ready  out  registered !full; a word is taken on push_valid & push_ready
//   push_data   in   word to store
//   pop         in   remove the head word (ignored when empty)
//   pop_data    out  current head word
//   empty       out  no words stored
//   level       out  number of words stored
module serdes_sync_fifo
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ready_q;
  logic        full_d;
  logic        do_push;
  logic        do_pop;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign level      = wr_ptr_q - rd_ptr_q;
  assign push_ready = ready_q;
  assign pop_data   = mem_q[rd_ptr_q[AW-1:0]];

  // Push is gated by the registered ready, so a slot freed by a pop only
  // becomes usable one cycle later.
  assign do_push = push_valid & ready_q;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
             (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ~full_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule : serdes_sync_fifo

// File: rtl/serdes_byte_serializer.sv
// rtl/serdes_byte_serializer.sv - parallel-to-serial transmit half of the serdes link
//
// Purpose: queues parallel words in a small FIFO and shifts them onto one
// serial line, one bit per clock, back to back with no idle gaps.
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   ena        in   shift enable; 0 freezes the shifter (FIFO still accepts)
//   in_data    in   parallel word
//   in_valid   in   in_data is valid
//   in_ready   out  FIFO can accept a word (registered !full)
//   ser_out    out  registered serial data
//   ser_frame  out  high while ser_out carries the first bit of a word
//   busy       out  shifter holds a word or FIFO is non-empty
//   level      out  FIFO occupancy
module serdes_byte_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              ser_out,
  output logic                              ser_frame,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_frame_q, ser_frame_d;

  logic              fifo_pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  serdes_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_data),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .empty      (fifo_empty),
    .level      (level)
  );

  assign ser_out   = ser_out_q;
  assign ser_frame = ser_frame_q;
  assign busy      = (state_q == ST_SHIFT) || (level != '0);

  // The shift register holds only the bits not yet driven: on load the first
  // bit goes straight to ser_out and the remainder is pre-shifted, so the next
  // bit to send is always at the outgoing end of shreg_q.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    ser_out_d   = ser_out_q;
    ser_frame_d = ser_frame_q;
    fifo_pop    = 1'b0;

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          ser_out_d   = IDLE_LEVEL;
          ser_frame_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            ser_out_d   = LSB_FIRST ? fifo_data[0] : fifo_data[DATA_W-1];
            shreg_d     = LSB_FIRST ? (fifo_data >> 1) : (fifo_data << 1);
            ser_frame_d = 1'b1;
            bitcnt_d    = '0;
            state_d     = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bitcnt_q != CNT_LAST) begin
            ser_out_d   = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1];
            shreg_d     = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            bitcnt_d    = bitcnt_q + CNT_ONE;
            ser_frame_d = 1'b0;
          end else if (!fifo_empty) begin
            // Chain the next word on the same edge so there is no gap.
            fifo_pop    = 1'b1;
            ser_out_d   = LSB_FIRST ? fifo_data[0] : fifo_data[DATA_W-1];
            shreg_d     = LSB_FIRST ? (fifo_data >> 1) : (fifo_data << 1);
            ser_frame_d = 1'b1;
            bitcnt_d    = '0;
          end else begin
            ser_out_d   = IDLE_LEVEL;
            ser_frame_d = 1'b0;
            bitcnt_d    = '0;
            state_d     = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
    end
  end

endmodule : serdes_byte_serializer

// File: tb/tb_serdes_byte_serializer.sv
// tb/tb_serdes_byte_serializer.sv - directed self-checking bench for serdes_byte_serializer
module tb_serdes_byte_serializer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_frame;
  logic       busy;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  serdes_byte_serializer #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .LSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_frame (ser_frame),
    .busy      (busy),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // bits[i] / frames[i] are the values expected on the i-th following cycle.
  task automatic check_stream(input string tag, input logic [31:0] bits,
                              input logic [31:0] frames, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s ser_out bit%0d", tag, i), {31'b0, ser_out}, {31'b0, bits[i]});
      chk($sformatf("%s ser_frame bit%0d", tag, i), {31'b0, ser_frame}, {31'b0, frames[i]});
    end
  endtask

  initial begin
    int n;
    int ones;
    int frames;
    int high;
    int busy_cnt;

    rst      = 1'b1;
    ena      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset ser_out", {31'b0, ser_out}, 32'd0);
    chk("reset ser_frame", {31'b0, ser_frame}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset level", {29'b0, level}, 32'd0);

    // 1: all-zero word, frame pulses once, then idle
    ena = 1'b1;
    push(8'h00);
    chk("t1 level after push", {29'b0, level}, 32'd1);
    chk("t1 busy after push", {31'b0, busy}, 32'd1);
    check_stream("t1", 32'h0000_0000, 32'h0000_0001, 8);
    tick();
    chk("t1 busy end", {31'b0, busy}, 32'd0);

    // 2: 0xA5 LSB first -> 1,0,1,0,0,1,0,1
    push(8'hA5);
    check_stream("t2", 32'h0000_00A5, 32'h0000_0001, 8);
    tick();
    chk("t2 ser_out idle", {31'b0, ser_out}, 32'd0);
    chk("t2 busy end", {31'b0, busy}, 32'd0);

    // 3: 0x3C then 0xC3 back to back, 16 contiguous bits
    push(8'h3C);
    in_data  = 8'hC3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t3 bit0", {31'b0, ser_out}, 32'd0);
    chk("t3 frame0", {31'b0, ser_frame}, 32'd1);
    chk("t3 level push+pop", {29'b0, level}, 32'd1);
    check_stream("t3", 32'h0000_619E, 32'h0000_0080, 15);
    tick();
    chk("t3 busy end", {31'b0, busy}, 32'd0);

    // 4: frozen shifter fills FIFO, then release
    ena = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("t4 level3", {29'b0, level}, 32'd3);
    push(8'h44);
    chk("t4 level full", {29'b0, level}, 32'd4);
    chk("t4 in_ready full", {31'b0, in_ready}, 32'd0);
    chk("t4 ser_out frozen", {31'b0, ser_out}, 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    tick();
    chk("t4 no push when full", {29'b0, level}, 32'd4);
    ena = 1'b1;
    tick();
    chk("t4 level after pop", {29'b0, level}, 32'd3);
    chk("t4 in_ready after pop", {31'b0, in_ready}, 32'd1);
    chk("t4 first bit", {31'b0, ser_out}, 32'd1);
    chk("t4 first frame", {31'b0, ser_frame}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4 held word pushed", {29'b0, level}, 32'd4);
    chk("t4 in_ready refull", {31'b0, in_ready}, 32'd0);
    n = 0;
    ones = 0;
    frames = 0;
    while (busy && n < 100) begin
      tick();
      n++;
      ones += int'(ser_out);
      frames += int'(ser_frame);
    end
    chk("t4 drain cycles", n, 32'd39);
    chk("t4 drain ones", ones, 32'd13);
    chk("t4 drain frames", frames, 32'd4);

    // 5: 0xFF with ena dropped for 3 cycles after bit 2
    push(8'hFF);
    high = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 bit%0d", i), {31'b0, ser_out}, 32'd1);
      high += int'(ser_out);
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 hold%0d", i), {31'b0, ser_out}, 32'd1);
      chk($sformatf("t5 hold frame%0d", i), {31'b0, ser_frame}, 32'd0);
      high += int'(ser_out);
    end
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      high += int'(ser_out);
    end
    chk("t5 high time", high, 32'd11);
    chk("t5 ser_out idle", {31'b0, ser_out}, 32'd0);
    chk("t5 busy end", {31'b0, busy}, 32'd0);

    // 6: reset mid-word with two words queued
    push(8'h81);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_data = 8'h6B;
    tick();
    in_valid = 1'b0;
    chk("t6 level queued", {29'b0, level}, 32'd2);
    tick();
    tick();
    tick();
    chk("t6 level at bit4", {29'b0, level}, 32'd2);
    chk("t6 busy at bit4", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t6 rst ser_out", {31'b0, ser_out}, 32'd0);
    chk("t6 rst level", {29'b0, level}, 32'd0);
    chk("t6 rst busy", {31'b0, busy}, 32'd0);
    chk("t6 rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("t6 rst frame", {31'b0, ser_frame}, 32'd0);
    rst = 1'b0;
    ones = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ones += int'(ser_out);
      busy_cnt += int'(busy);
    end
    chk("t6 no residual bits", ones, 32'd0);
    chk("t6 no residual busy", busy_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serdes_byte_serializer
